// File: rtl/rtc_bus_controller.sv
// Multiplexed address/data bus master for an external RTC: runs one init, write
// or read cycle per start and pulses fin for one clock when the cycle completes.
module rtc_bus_controller #(
    parameter int unsigned T_FASE    = 10,
    parameter logic [7:0]  INIT_DIR  = 8'h02,
    parameter logic [7:0]  INIT_DATO = 8'h10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arranque_inicio,
    input  logic       arranque_escribe,
    input  logic       arranque_lee,
    input  logic [7:0] direccion,
    input  logic [7:0] dato,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       ad_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic [7:0] dato_leido,
    output logic       ocupado,
    output logic       fin
);

    typedef enum logic [3:0] {
        StIdle, StDirSetup, StDirStrobe, StDirHold, StPausa,
        StDatSetup, StDatStrobe, StDatHold, StFin
    } state_e;

    typedef enum logic [1:0] {OpInit, OpWr, OpRd} op_e;

    localparam logic [7:0] LAST = 8'(T_FASE - 1);

    state_e     state_q, state_d;
    op_e        op_q, op_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] data_q, data_d;
    logic [7:0] leido_q;
    logic       last;

    assign last = (cnt_q == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            op_q    <= OpInit;
            cnt_q   <= 8'h00;
            addr_q  <= 8'h00;
            data_q  <= 8'h00;
            leido_q <= 8'h00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            // Capture at the very end of the read strobe, when the RTC data is settled.
            if (state_q == StDatStrobe && op_q == OpRd && last) begin
                leido_q <= ad_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = 8'h00;
        addr_d  = addr_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (arranque_inicio) begin
                    op_d    = OpInit;
                    addr_d  = INIT_DIR;
                    data_d  = INIT_DATO;
                    state_d = StDirSetup;
                end else if (arranque_escribe || arranque_lee) begin
                    op_d    = arranque_escribe ? OpWr : OpRd;
                    addr_d  = direccion;
                    data_d  = dato;
                    state_d = StDirSetup;
                end
            end
            StFin: state_d = StIdle;
            default: begin
                if (last) begin
                    unique case (state_q)
                        StDirSetup:  state_d = StDirStrobe;
                        StDirStrobe: state_d = StDirHold;
                        StDirHold:   state_d = StPausa;
                        StPausa:     state_d = StDatSetup;
                        StDatSetup:  state_d = StDatStrobe;
                        StDatStrobe: state_d = StDatHold;
                        default:     state_d = StFin;
                    endcase
                end else begin
                    cnt_d = cnt_q + 8'h01;
                end
            end
        endcase
    end

    always_comb begin
        cs_n    = 1'b1;
        ad_n    = 1'b1;
        wr_n    = 1'b1;
        rd_n    = 1'b1;
        ad_oe   = 1'b0;
        ad_out  = 8'h00;
        fin     = 1'b0;
        ocupado = (state_q != StIdle);
        unique case (state_q)
            StDirSetup, StDirStrobe, StDirHold: begin
                cs_n   = 1'b0;
                ad_n   = 1'b0;
                ad_oe  = 1'b1;
                ad_out = addr_q;
                wr_n   = (state_q != StDirStrobe);
            end
            StDatSetup, StDatStrobe, StDatHold: begin
                cs_n = 1'b0;
                if (op_q == OpRd) begin
                    rd_n = (state_q != StDatStrobe);
                end else begin
                    ad_oe  = 1'b1;
                    ad_out = data_q;
                    wr_n   = (state_q != StDatStrobe);
                end
            end
            StFin:   fin = 1'b1;
            default: ;
        endcase
    end

    assign dato_leido = leido_q;

endmodule

// File: tb/tb_rtc_bus_controller.sv
// Directed bench for rtc_bus_controller with T_FASE = 2: cycle-by-cycle traces of
// write, read and init transactions plus reset, ignored-start and retrigger cases.
module tb_rtc_bus_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       arranque_inicio = 1'b0, arranque_escribe = 1'b0, arranque_lee = 1'b0;
    logic [7:0] direccion = 8'h00, dato = 8'h00, ad_in = 8'hAA;
    logic [7:0] ad_out, dato_leido;
    logic       ad_oe, cs_n, ad_n, wr_n, rd_n, ocupado, fin;

    int tests = 0;
    int failed = 0;

    // Per-cycle trace, index = cycles after the start edge
    logic [7:0] t_out [0:17];
    logic [7:0] t_leido [0:17];
    logic       t_oe [0:17], t_cs [0:17], t_adn [0:17], t_wr [0:17];
    logic       t_rd [0:17], t_oc [0:17], t_fin [0:17];
    int         nfin, nclash;

    rtc_bus_controller #(.T_FASE(2)) dut (
        .clk(clk), .reset(reset),
        .arranque_inicio(arranque_inicio), .arranque_escribe(arranque_escribe),
        .arranque_lee(arranque_lee), .direccion(direccion), .dato(dato),
        .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .ad_n(ad_n),
        .wr_n(wr_n), .rd_n(rd_n), .dato_leido(dato_leido), .ocupado(ocupado), .fin(fin)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Caller sets up the start inputs; the first tick is the start edge.
    task automatic capture(input bit clr, input bit mid_lee, input bit hold_clr);
        nfin = 0;
        nclash = 0;
        for (int i = 1; i <= 17; i++) begin
            tick();
            if (i == 1 && clr) begin
                arranque_inicio = 1'b0;
                arranque_escribe = 1'b0;
                arranque_lee = 1'b0;
            end
            if (mid_lee && i == 5) arranque_lee = 1'b1;
            if (hold_clr && i > 1 && t_fin[i-1]) arranque_escribe = 1'b0;
            ad_in = (i == 12) ? 8'h59 : 8'hAA;
            #1;
            t_out[i] = ad_out; t_oe[i] = ad_oe; t_cs[i] = cs_n; t_adn[i] = ad_n;
            t_wr[i] = wr_n; t_rd[i] = rd_n; t_oc[i] = ocupado; t_fin[i] = fin;
            t_leido[i] = dato_leido;
            if (fin) nfin++;
            if (ad_oe && !rd_n) nclash++;
        end
    endtask

    initial begin
        #3;
        check("rst_cs_n", cs_n, 1'b1);
        check("rst_wr_rd", {wr_n, rd_n, ad_n}, 3'b111);
        check("rst_oe_fin_oc", {ad_oe, fin, ocupado}, 3'b000);
        check("rst_ad_out", ad_out, 8'h00);
        check("rst_leido", dato_leido, 8'h00);
        tick();
        reset = 1'b1;
        tick();

        // Write 0x45 to 0x23
        direccion = 8'h23; dato = 8'h45; arranque_escribe = 1'b1;
        capture(1'b1, 1'b0, 1'b0);
        check("wr_c1_bus", {t_cs[1], t_adn[1], t_oe[1], t_wr[1]}, 4'b0011);
        check("wr_c1_addr", t_out[1], 8'h23);
        check("wr_c1_oc", t_oc[1], 1'b1);
        check("wr_c2_wr", t_wr[2], 1'b1);
        check("wr_addr_strobe", {t_wr[3], t_wr[4], t_wr[5]}, 3'b001);
        check("wr_c4_addr", t_out[4], 8'h23);
        check("wr_c6_addr", t_out[6], 8'h23);
        check("wr_pausa", {t_cs[7], t_oe[7], t_adn[7], t_cs[8]}, 4'b1011);
        check("wr_c9_bus", {t_cs[9], t_adn[9], t_oe[9], t_wr[9]}, 4'b0111);
        check("wr_c9_data", t_out[9], 8'h45);
        check("wr_dat_strobe", {t_wr[10], t_wr[11], t_wr[12], t_wr[13]}, 4'b1001);
        check("wr_c14_data", t_out[14], 8'h45);
        check("wr_fin_c14", t_fin[14], 1'b0);
        check("wr_fin_c15", t_fin[15], 1'b1);
        check("wr_c15_idle", {t_cs[15], t_oe[15], t_oc[15]}, 3'b101);
        check("wr_c16", {t_fin[16], t_oc[16]}, 2'b00);
        check("wr_nfin", 8'(nfin), 8'd1);
        check("wr_leido", t_leido[16], 8'h00);

        // Read from 0x24, RTC returns 0x59 on the last strobe cycle
        direccion = 8'h24; dato = 8'h77; arranque_lee = 1'b1;
        capture(1'b1, 1'b0, 1'b0);
        check("rd_c1_addr", t_out[1], 8'h24);
        check("rd_rd_n", {t_rd[10], t_rd[11], t_rd[12], t_rd[13]}, 4'b1001);
        check("rd_oe_data", {t_oe[9], t_oe[10], t_oe[11], t_oe[12], t_oe[13], t_oe[14]},
              6'b000000);
        check("rd_wr_data", {t_wr[11], t_wr[12]}, 2'b11);
        check("rd_c12_leido", t_leido[12], 8'h00);
        check("rd_c13_leido", t_leido[13], 8'h59);
        check("rd_fin_c15", t_fin[15], 1'b1);
        check("rd_clash", 8'(nclash), 8'd0);
        check("rd_leido_after", t_leido[17], 8'h59);

        // All three starts together: init wins
        direccion = 8'h99; dato = 8'h88;
        arranque_inicio = 1'b1; arranque_escribe = 1'b1; arranque_lee = 1'b1;
        capture(1'b1, 1'b0, 1'b0);
        check("init_addr", t_out[1], 8'h02);
        check("init_data", t_out[9], 8'h10);
        check("init_wr", t_wr[11], 1'b0);
        check("init_nfin", 8'(nfin), 8'd1);
        check("init_leido", t_leido[17], 8'h59);

        // Reset during the data strobe of a write
        direccion = 8'h23; dato = 8'h45; arranque_escribe = 1'b1;
        tick();
        arranque_escribe = 1'b0;
        repeat (10) tick();
        check("rstmid_pre_wr", wr_n, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("rstmid_bus", {cs_n, wr_n, ad_oe, ocupado}, 4'b1100);
        nfin = 0;
        repeat (3) begin
            tick();
            if (fin) nfin++;
        end
        check("rstmid_nofin", 8'(nfin), 8'd0);
        reset = 1'b1;
        tick();
        check("rstmid_after", {ocupado, cs_n, fin}, 3'b010);
        check("rstmid_leido", dato_leido, 8'h00);

        // Read request during a write is ignored, then starts because it stays high
        direccion = 8'h24; dato = 8'h45; arranque_escribe = 1'b1;
        capture(1'b1, 1'b1, 1'b0);
        check("mid_nfin", 8'(nfin), 8'd1);
        check("mid_fin_c15", t_fin[15], 1'b1);
        check("mid_c16_idle", t_oc[16], 1'b0);
        check("mid_leido", t_leido[16], 8'h00);
        check("mid_c17_start", t_oc[17], 1'b1);
        check("mid_c17_addr", t_out[17], 8'h24);
        arranque_lee = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                tick();
                ad_in = 8'hAA;
                if (fin) seen = 1'b1;
            end
            check("mid_rd_fin_seen", seen, 1'b1);
        end
        tick();
        check("mid_rd_leido", dato_leido, 8'hAA);

        // Start held until the edge after fin: exactly one transaction
        direccion = 8'h30; dato = 8'h31; arranque_escribe = 1'b1;
        capture(1'b0, 1'b0, 1'b1);
        check("b2b_nfin", 8'(nfin), 8'd1);
        check("b2b_fin_c15", t_fin[15], 1'b1);
        check("b2b_noretrig", {t_oc[16], t_oc[17]}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
